irq_ctrl: RTL

- Parametrised N-source interrupt controller in front of the MIPS core's single `interrupt` input. It replaces direct wiring of one interrupt line.
- Latches and masks sources, then arbitrates them by fixed priority. It presents a vector address and handshakes with the core.
- Captures the interrupted `current_address` as EPC, and holds off further requests until the core signals return (`eret`).

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_ctrl_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the fixed-priority interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int unsigned DEF_VEC_BASE   = 32'h0000_0040;
  localparam int unsigned DEF_VEC_STRIDE = 32'd4;

  // Index width for n sources; kept at least 1 so a single-source build still has a port.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: valid flags any request, idx is the winner.
module prio_enc #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// N-source interrupt controller: edge/level pending, enable mask, fixed priority,
// vectored request/ack handshake with EPC capture and eret-terminated service.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter int          ADDR_W     = 16,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int         ID_W       = id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic               en_wr,
  input  logic [NUM_SRC-1:0] en_in,
  input  logic [ADDR_W-1:0]  current_address,
  input  logic               irq_ack,
  input  logic               eret,
  output logic               irq_req,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic [ID_W-1:0]    cause_id,
  output logic [ADDR_W-1:0]  epc,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  // Handshake: irq_req stays high with stable vec_addr/cause_id until the cycle
  // irq_ack=1 is seen; that cycle completes the transfer and enters SERVICE.
  irq_state_t state;

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] en_reg;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] edge_clr;
  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic [ADDR_W-1:0]  win_vec;

  assign edge_set = irq_src & ~src_d & edge_mode;
  assign pending  = (edge_pend & edge_mode) | (irq_src & ~edge_mode);
  assign eligible = pending & en_reg;
  assign win_vec  = ADDR_W'(VEC_BASE) + ADDR_W'(win_idx) * ADDR_W'(VEC_STRIDE);

  prio_enc #(
    .N   (NUM_SRC),
    .IDW (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Only the acknowledged source loses its latched edge.
  always_comb begin
    edge_clr = '0;
    if (state == REQ && irq_ack) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        edge_clr[i] = (cause_id == ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_d      <= '0;
      edge_pend  <= '0;
      en_reg     <= '0;
      irq_req    <= 1'b0;
      in_service <= 1'b0;
      cause_id   <= '0;
      vec_addr   <= '0;
      epc        <= '0;
    end else begin
      src_d <= irq_src;
      if (en_wr) en_reg <= en_in;
      // A new edge in the ack cycle wins over the clear.
      edge_pend <= (edge_pend & ~edge_clr) | edge_set;

      case (state)
        IDLE: begin
          if (win_valid) begin
            cause_id <= win_idx;
            vec_addr <= win_vec;
            irq_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            epc        <= current_address;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eret) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
